// File: rtl/fft_stage_seq.sv
// Control sequencer for one radix-2 delay-feedback FFT stage.
// It drives the delay-line, butterfly, output mux and twiddle index for a stream of 16-lane beats.
module fft_stage_seq #(
   parameter int DLY   = 2,
   parameter int CNT_W = $clog2(DLY) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             shift_en,
   output logic             bfly_en,
   output logic             dl_src,
   output logic             out_sel,
   output logic             out_valid,
   output logic [CNT_W-1:0] tw_idx,
   output logic             blk_done,
   output logic             err
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DLY - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_BFLY,
      S_SWAP,
      S_DRAIN
   } state_t;

   // r_state/r_cnt describe the beat whose control is on the outputs this cycle
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_last;
   logic             r_err;
   logic             w_err_nxt;

   logic             r_shift_en, w_shift_en;
   logic             r_bfly_en, w_bfly_en;
   logic             r_dl_src, w_dl_src;
   logic             r_out_sel, w_out_sel;
   logic             r_out_valid, w_out_valid;
   logic [CNT_W-1:0] r_tw_idx, w_tw_idx;
   logic             r_blk_done, w_blk_done;

   assign w_last = (r_cnt == LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = S_FILL;
               w_cnt_nxt   = '0;
            end
         end
         S_FILL: begin
            if (!in_valid) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_last) begin
               w_state_nxt = S_BFLY;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
         S_BFLY: begin
            // the last butterfly cycle decides between streaming on and draining
            if (w_last) begin
               w_state_nxt = in_valid ? S_SWAP : S_DRAIN;
               w_cnt_nxt   = '0;
            end else if (!in_valid) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
         S_SWAP: begin
            if (!in_valid) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_last) begin
               w_state_nxt = S_BFLY;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
         S_DRAIN: begin
            // beats offered while draining are dropped and flagged
            if (in_valid) begin
               w_err_nxt = 1'b1;
            end
            if (w_last) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_shift_en  = (w_state_nxt != S_IDLE);
      w_bfly_en   = (w_state_nxt == S_BFLY);
      w_dl_src    = (w_state_nxt == S_BFLY);
      w_out_sel   = (w_state_nxt == S_SWAP) || (w_state_nxt == S_DRAIN);
      w_out_valid = (w_state_nxt == S_BFLY) || (w_state_nxt == S_SWAP) ||
                    (w_state_nxt == S_DRAIN);
      w_tw_idx    = (w_state_nxt == S_BFLY) ? w_cnt_nxt : '0;
      w_blk_done  = (w_state_nxt == S_DRAIN) && (w_cnt_nxt == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_shift_en  <= 1'b0;
         r_bfly_en   <= 1'b0;
         r_dl_src    <= 1'b0;
         r_out_sel   <= 1'b0;
         r_out_valid <= 1'b0;
         r_tw_idx    <= '0;
         r_blk_done  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_err       <= w_err_nxt;
         r_shift_en  <= w_shift_en;
         r_bfly_en   <= w_bfly_en;
         r_dl_src    <= w_dl_src;
         r_out_sel   <= w_out_sel;
         r_out_valid <= w_out_valid;
         r_tw_idx    <= w_tw_idx;
         r_blk_done  <= w_blk_done;
      end
   end

   assign in_ready  = (r_state != S_DRAIN);
   assign shift_en  = r_shift_en;
   assign bfly_en   = r_bfly_en;
   assign dl_src    = r_dl_src;
   assign out_sel   = r_out_sel;
   assign out_valid = r_out_valid;
   assign tw_idx    = r_tw_idx;
   assign blk_done  = r_blk_done;
   assign err       = r_err;

endmodule
